// File: rtl/pc_ctrl.sv
// Program-counter controller for the multicycle NPC core.
// Holds the architectural PC and offers it to the IFU through a valid/ready
// handshake. It then waits for the EXU resolution of that instruction and
// picks the next PC: sequential, branch/jump target, or trap vector. It also
// counts retired instructions and reports halt and misaligned-target status.
module pc_ctrl #(
    parameter int unsigned       XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_VEC  = 32'h8000_0000,
    parameter int unsigned       INST_BYTES = 4,
    parameter int unsigned       ALIGN_BITS = 2,
    parameter int unsigned       CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pc_valid,
    input  logic             pc_ready,
    output logic [XLEN-1:0]  pc_out,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [2:0]       ex_br_type,
    input  logic             ex_cmp,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             halt,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             misalign
);

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;
    localparam logic [2:0] BR_JUMP = 3'd7;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              misalign_q, misalign_d;

    logic              taken;
    logic              tgt_misaligned;
    logic [XLEN-1:0]   seq_pc;

    // Sequential successor; the adder simply wraps at the top of the address space.
    assign seq_pc = pc_q + XLEN'(INST_BYTES);

    // Alignment check on the target's low bits; a zero width disables it entirely.
    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign tgt_misaligned = |ex_target[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign tgt_misaligned = 1'b0;
        end
    endgenerate

    // Branch decision: ex_cmp means "operands differ" for EQ/NE, "less than" otherwise.
    always_comb begin
        taken = 1'b0;
        case (ex_br_type)
            BR_NONE: taken = 1'b0;
            BR_EQ:   taken = !ex_cmp;
            BR_NE:   taken = ex_cmp;
            BR_LT:   taken = ex_cmp;
            BR_GE:   taken = !ex_cmp;
            BR_LTU:  taken = ex_cmp;
            BR_GEU:  taken = !ex_cmp;
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Next-state logic: issue, wait for the resolution, then select the next PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        misalign_d = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = halt ? S_HALT : S_ISSUE;
            end
            S_ISSUE: begin
                // halt is deliberately ignored here; the offer is never withdrawn.
                if (pc_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ex_valid) begin
                    state_d = halt ? S_HALT : S_ISSUE;
                    if (trap_valid) begin
                        pc_d = trap_vec;
                    end else if (taken && tgt_misaligned) begin
                        // Keep the faulting PC visible and stop; nothing retires.
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else if (taken) begin
                        pc_d      = ex_target;
                        instret_d = instret_q + CNT_W'(1);
                    end else begin
                        pc_d      = seq_pc;
                        instret_d = instret_q + CNT_W'(1);
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State registers; reset wins over any handshake pending in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VEC;
            instret_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_valid = (state_q == S_ISSUE);
    assign ex_ready = (state_q == S_WAIT);
    assign halted   = (state_q == S_HALT);
    assign pc_out   = pc_q;
    assign instret  = instret_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: a vector table for sequential, branch-matrix
// and trap cases, plus hand-written sequences for back-pressure, misalign,
// halt and reset corner cases. A second instance with a top-of-memory reset
// vector runs in lockstep on the same inputs to observe PC wrap-around.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_ready;
    logic        ex_valid;
    logic [2:0]  ex_br_type;
    logic        ex_cmp;
    logic [31:0] ex_target;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        halt;

    logic        pc_valid, ex_ready, halted, misalign;
    logic [31:0] pc_out;
    logic [63:0] instret;

    logic        w_pc_valid, w_ex_ready, w_halted, w_misalign;
    logic [31:0] w_pc_out;
    logic [63:0] w_instret;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  br;
        logic        cmp;
        logic [31:0] tgt;
        logic        trap;
        logic [31:0] tvec;
        logic        hlt;
        int          dly;
        logic [31:0] exp_issue;
        logic [31:0] exp_next;
        logic [63:0] exp_ir;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_ctrl u_dut (
        .clk(clk), .rst(rst),
        .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_out(pc_out),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_br_type(ex_br_type),
        .ex_cmp(ex_cmp), .ex_target(ex_target), .trap_valid(trap_valid),
        .trap_vec(trap_vec), .halt(halt), .instret(instret),
        .halted(halted), .misalign(misalign)
    );

    pc_ctrl #(.RESET_VEC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .pc_valid(w_pc_valid), .pc_ready(pc_ready), .pc_out(w_pc_out),
        .ex_valid(ex_valid), .ex_ready(w_ex_ready), .ex_br_type(ex_br_type),
        .ex_cmp(ex_cmp), .ex_target(ex_target), .trap_valid(trap_valid),
        .trap_vec(trap_vec), .halt(halt), .instret(w_instret),
        .halted(w_halted), .misalign(w_misalign)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_pc_valid();
        int n = 0;
        while (pc_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pc_valid_wait", {63'd0, pc_valid}, 64'd1);
    endtask

    // Handshake one instruction, resolve it after v.dly idle WAIT cycles.
    task automatic run_instr(input vec_t v, output logic [31:0] issued);
        pc_ready = 1'b1;
        wait_pc_valid();
        issued = pc_out;
        @(negedge clk);
        pc_ready = 1'b0;
        chk("ex_ready_after_hs", {63'd0, ex_ready}, 64'd1);
        repeat (v.dly) @(negedge clk);
        ex_valid   = 1'b1;
        ex_br_type = v.br;
        ex_cmp     = v.cmp;
        ex_target  = v.tgt;
        trap_valid = v.trap;
        trap_vec   = v.tvec;
        halt       = v.hlt;
        @(negedge clk);
        ex_valid   = 1'b0;
        ex_br_type = 3'd0;
        ex_cmp     = 1'b0;
        trap_valid = 1'b0;
        halt       = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] br, input logic cmp, input logic [31:0] tgt,
                                input logic trap, input logic [31:0] tvec, input int dly,
                                input logic [31:0] ei, input logic [31:0] en, input logic [63:0] ir);
        vec_t v;
        v.br = br; v.cmp = cmp; v.tgt = tgt; v.trap = trap; v.tvec = tvec; v.hlt = 1'b0;
        v.dly = dly; v.exp_issue = ei; v.exp_next = en; v.exp_ir = ir;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] issued;
        logic [31:0] prev_next;
        logic [11:0] tk;
        vec_t        v;
        int          idx;

        // Hand-derived taken flags, index (type-1)*2 + cmp:
        // EQ0 T, EQ1 N, NE0 N, NE1 T, LT0 N, LT1 T, GE0 T, GE1 N, LTU0 N, LTU1 T, GEU0 T, GEU1 N
        tk = 12'b0110_0110_1001;

        // Sequential run from reset to 0x80000010.
        vecs.push_back(mk(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1, 32'h8000_0000, 32'h8000_0004, 64'd1));
        vecs.push_back(mk(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1, 32'h8000_0004, 32'h8000_0008, 64'd2));
        vecs.push_back(mk(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1, 32'h8000_0008, 32'h8000_000C, 64'd3));
        vecs.push_back(mk(3'd0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 0, 32'h8000_000C, 32'h8000_0010, 64'd4));
        // Branch matrix at 0x80000010, each followed by a jump back to 0x80000010.
        idx = 4;
        for (int t = 1; t <= 6; t++) begin
            for (int c = 0; c <= 1; c++) begin
                prev_next = tk[(t-1)*2+c] ? 32'h8000_0100 : 32'h8000_0014;
                vecs.push_back(mk(3'(t), 1'(c), 32'h8000_0100, 1'b0, 32'h0, (t + c) % 3,
                                  32'h8000_0010, prev_next, 64'(idx + 1)));
                vecs.push_back(mk(3'd7, 1'b0, 32'h8000_0010, 1'b0, 32'h0, 0,
                                  prev_next, 32'h8000_0010, 64'(idx + 2)));
                idx += 2;
            end
        end
        // Trap beats a taken jump; instret stays at 28.
        vecs.push_back(mk(3'd7, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_1000, 2,
                          32'h8000_0010, 32'h8000_1000, 64'd28));

        rst = 1'b1; pc_ready = 1'b0; ex_valid = 1'b0; ex_br_type = 3'd0; ex_cmp = 1'b0;
        ex_target = 32'h0; trap_valid = 1'b0; trap_vec = 32'h0; halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_pc", pc_out, 64'h8000_0000);
        chk("reset_instret", instret, 64'd0);
        chk("reset_pc_valid", {63'd0, pc_valid}, 64'd0);
        chk("reset_ex_ready", {63'd0, ex_ready}, 64'd0);
        chk("reset_halted", {63'd0, halted}, 64'd0);
        chk("reset_misalign", {63'd0, misalign}, 64'd0);
        chk("wrap_reset_pc", w_pc_out, 64'hFFFF_FFFC);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i], issued);
            $display("vec %0d: br=%0d cmp=%0d trap=%0d issued=%h next=%h instret=%0d",
                     i, vecs[i].br, vecs[i].cmp, vecs[i].trap, issued, pc_out, instret);
            chk($sformatf("vec%0d_issue_pc", i), issued, vecs[i].exp_issue);
            chk($sformatf("vec%0d_next_pc", i), pc_out, vecs[i].exp_next);
            chk($sformatf("vec%0d_instret", i), instret, vecs[i].exp_ir);
            chk($sformatf("vec%0d_misalign", i), {63'd0, misalign}, 64'd0);
            if (i == 0) chk("wrap_pc_after_seq", w_pc_out, 64'h0);
        end

        // Back-pressure: hold pc_ready low, then a slow resolution.
        pc_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_pc_valid_held", {63'd0, pc_valid}, 64'd1);
            chk("bp_pc_stable", pc_out, 64'h8000_1000);
            chk("bp_no_ex_ready", {63'd0, ex_ready}, 64'd0);
            @(negedge clk);
        end
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        chk("bp_ex_ready", {63'd0, ex_ready}, 64'd1);
        chk("bp_pc_valid_drop", {63'd0, pc_valid}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("bp_wait_ex_ready", {63'd0, ex_ready}, 64'd1);
            chk("bp_wait_instret", instret, 64'd28);
            @(negedge clk);
        end
        ex_valid = 1'b1; ex_br_type = 3'd0;
        @(negedge clk);
        ex_valid = 1'b0;
        $display("backpressure: pc=%h instret=%0d", pc_out, instret);
        chk("bp_next_pc", pc_out, 64'h8000_1004);
        chk("bp_instret", instret, 64'd29);

        // Misaligned jump halts without retiring.
        v = mk(3'd7, 1'b0, 32'h8000_0102, 1'b0, 32'h0, 0, 32'h8000_1004, 32'h8000_1004, 64'd29);
        run_instr(v, issued);
        $display("misalign: issued=%h pc=%h misalign=%0d halted=%0d", issued, pc_out, misalign, halted);
        chk("mis_issue_pc", issued, 64'h8000_1004);
        chk("mis_pulse", {63'd0, misalign}, 64'd1);
        chk("mis_halted", {63'd0, halted}, 64'd1);
        chk("mis_pc_kept", pc_out, 64'h8000_1004);
        chk("mis_instret", instret, 64'd29);
        @(negedge clk);
        chk("mis_pulse_end", {63'd0, misalign}, 64'd0);
        pc_ready = 1'b1; ex_valid = 1'b1; ex_br_type = 3'd7; ex_target = 32'h8000_0200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_no_issue", {63'd0, pc_valid}, 64'd0);
            chk("halt_no_accept", {63'd0, ex_ready}, 64'd0);
            chk("halt_pc_frozen", pc_out, 64'h8000_1004);
            chk("halt_instret_frozen", instret, 64'd29);
            chk("halt_misalign_low", {63'd0, misalign}, 64'd0);
        end
        pc_ready = 1'b0; ex_valid = 1'b0; ex_br_type = 3'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_after_halt_pc", pc_out, 64'h8000_0000);
        chk("rst_after_halt_instret", instret, 64'd0);
        chk("rst_after_halt_halted", {63'd0, halted}, 64'd0);

        // halt together with ex_valid: the instruction still retires.
        v = mk(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1, 32'h8000_0000, 32'h8000_0004, 64'd1);
        v.hlt = 1'b1;
        run_instr(v, issued);
        $display("halt: pc=%h instret=%0d halted=%0d", pc_out, instret, halted);
        chk("halt_retire_pc", pc_out, 64'h8000_0004);
        chk("halt_retire_instret", instret, 64'd1);
        chk("halt_state", {63'd0, halted}, 64'd1);
        chk("halt_pc_valid", {63'd0, pc_valid}, 64'd0);
        pc_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("halt_stays", {63'd0, pc_valid}, 64'd0);
        pc_ready = 1'b0;

        // Reset during WAIT with ex_valid pending: that resolution is discarded.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pc_ready = 1'b1;
        wait_pc_valid();
        @(negedge clk);
        pc_ready = 1'b0;
        chk("rstwait_ex_ready", {63'd0, ex_ready}, 64'd1);
        ex_valid = 1'b1; ex_br_type = 3'd7; ex_target = 32'h8000_0300; rst = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; ex_br_type = 3'd0; rst = 1'b0;
        $display("rst in wait: pc=%h instret=%0d", pc_out, instret);
        chk("rstwait_pc", pc_out, 64'h8000_0000);
        chk("rstwait_instret", instret, 64'd0);
        chk("rstwait_boot_no_valid", {63'd0, pc_valid}, 64'd0);
        chk("rstwait_no_ex_ready", {63'd0, ex_ready}, 64'd0);
        @(negedge clk);
        chk("rstwait_reissue", {63'd0, pc_valid}, 64'd1);

        // halt seen in BOOT goes straight to HALT.
        rst = 1'b1; halt = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        halt = 1'b0;
        $display("boot halt: halted=%0d pc_valid=%0d", halted, pc_valid);
        chk("boot_halt_halted", {63'd0, halted}, 64'd1);
        chk("boot_halt_no_issue", {63'd0, pc_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
